// File: rtl/sp_mem_be.sv
// Single-port synchronous RAM with valid/ready requests, byte enables, 1- or 2-cycle read latency
// and an optional power-up clear. Per-byte even parity is included when SPM_PARITY_EN is defined.
module sp_mem_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [DATA_WIDTH/8-1:0] i_req_be,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  output logic                    o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_perr,
  output logic                    o_init_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH:0]     clr_cnt;
  logic                    clr_last;
  logic                    clr_we;
  logic                    ready;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_perr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    clr_we     = 1'b0;
    case (state)
      ST_INIT: begin
        if (INIT_CLEAR != 0) begin
          clr_we = 1'b1;
          if (clr_last) begin
            state_next = ST_IDLE;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // The clear counter restarts from address 0 on every reset.
  assign clr_last = (clr_cnt == (ADDR_WIDTH + 1)'(DEPTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_cnt <= '0;
    end else if (clr_we) begin
      clr_cnt <= clr_cnt + (ADDR_WIDTH + 1)'(1);
    end
  end

  assign o_req_ready = ready;
  assign o_init_done = ready;
  assign accept      = i_req_valid & ready;
  assign wr_acc      = accept & i_req_we;
  assign rd_acc      = accept & ~i_req_we;

  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (i_req_be[b]) begin
          mem[i_req_addr][8*b +: 8] <= i_req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data only loads on an accepted read, so it holds between responses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[i_req_addr];
      end
    end
  end

`ifdef SPM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_par;

  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      par_mem[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (i_req_be[b]) begin
          par_mem[i_req_addr][b] <= ^i_req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_par <= '0;
    end else if (rd_acc) begin
      rd_par <= par_mem[i_req_addr];
    end
  end

  always_comb begin
    rd_perr = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if ((^rd_data[8*b +: 8]) != rd_par[b]) begin
        rd_perr = 1'b1;
      end
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  out_valid;
      logic [DATA_WIDTH-1:0] out_data;
      logic                  out_perr;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_perr  <= 1'b0;
        end else begin
          out_valid <= rd_valid;
          if (rd_valid) begin
            out_data <= rd_data;
            out_perr <= rd_perr;
          end
        end
      end

      assign o_rsp_valid = out_valid;
      assign o_rsp_rdata = out_data;
      assign o_rsp_perr  = out_valid & out_perr;
    end else begin : g_no_out_reg
      assign o_rsp_valid = rd_valid;
      assign o_rsp_rdata = rd_data;
      assign o_rsp_perr  = rd_valid & rd_perr;
    end
  endgenerate

endmodule

// File: tb/tb_sp_mem_be.sv
// Bench for sp_mem_be: one instance with 1-cycle and one with 2-cycle read latency share all inputs.
// Define SPM_PARITY_EN to also exercise the parity error path.
module tb_sp_mem_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_be;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;

  logic        ready0, rvalid0, perr0, done0;
  logic [31:0] rdata0;
  logic        ready1, rvalid1, perr1, done1;
  logic [31:0] rdata1;

  int check_count = 0;
  int pass_count  = 0;

  // Expected held read data and the one-cycle-delayed expectation for the OUT_REG=1 instance.
  logic [31:0] hold0, hold1, prev_d;
  logic        prev_v, prev_p;

  typedef struct {
    logic        valid;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic        exp_perr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sp_mem_be #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .OUT_REG(0), .INIT_CLEAR(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(ready0),
    .i_req_we(req_we), .i_req_be(req_be), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rvalid0), .o_rsp_rdata(rdata0), .o_rsp_perr(perr0), .o_init_done(done0)
  );

  sp_mem_be #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .OUT_REG(1), .INIT_CLEAR(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(ready1),
    .i_req_we(req_we), .i_req_be(req_be), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rvalid1), .o_rsp_rdata(rdata1), .o_rsp_perr(perr1), .o_init_done(done1)
  );

  function automatic void add_vec(input logic v, input logic we, input logic [3:0] be,
                                  input logic [7:0] addr, input logic [31:0] wd,
                                  input logic ev, input logic [31:0] er, input logic ep);
    vec_t t;
    t.valid = v; t.we = we; t.be = be; t.addr = addr; t.wdata = wd;
    t.exp_valid = ev; t.exp_rdata = er; t.exp_perr = ep;
    vecs.push_back(t);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_count++;
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    req_valid = v.valid;
    req_we    = v.we;
    req_be    = v.be;
    req_addr  = v.addr;
    req_wdata = v.wdata;
  endtask

  task automatic set_idle();
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 8'h00; req_wdata = 32'h0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ready0"}, ready0, 0);
    check_output({tag, "_valid0"}, rvalid0, 0);
    check_output({tag, "_rdata0"}, rdata0, 0);
    check_output({tag, "_perr0"}, perr0, 0);
    check_output({tag, "_done0"}, done0, 0);
    check_output({tag, "_ready1"}, ready1, 0);
    check_output({tag, "_valid1"}, rvalid1, 0);
    check_output({tag, "_rdata1"}, rdata1, 0);
    check_output({tag, "_done1"}, done1, 0);
  endtask

  // Counts rising edges from reset release until ready; any response seen meanwhile is an error.
  task automatic wait_init(input string tag);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (rvalid0 || rvalid1) seen = 1'b1;
    end while (!ready0 && n < 2000);
    set_idle();
    check_output({tag, "_init_cycles"}, n, 256);
    check_output({tag, "_ready1"}, ready1, 1);
    check_output({tag, "_done0"}, done0, 1);
    check_output({tag, "_done1"}, done1, 1);
    check_output({tag, "_no_rsp_in_init"}, seen, 0);
    @(negedge clk);
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      if (vecs[i].exp_valid) hold0 = vecs[i].exp_rdata;
      if (prev_v) hold1 = prev_d;
      check_output($sformatf("%s%0d_valid0", tag, i), rvalid0, vecs[i].exp_valid);
      check_output($sformatf("%s%0d_rdata0", tag, i), rdata0, hold0);
      check_output($sformatf("%s%0d_perr0", tag, i), perr0, vecs[i].exp_perr);
      check_output($sformatf("%s%0d_valid1", tag, i), rvalid1, prev_v);
      check_output($sformatf("%s%0d_rdata1", tag, i), rdata1, hold1);
      check_output($sformatf("%s%0d_perr1", tag, i), perr1, prev_p);
      check_output($sformatf("%s%0d_ready0", tag, i), ready0, 1);
      prev_v = vecs[i].exp_valid;
      prev_d = vecs[i].exp_rdata;
      prev_p = vecs[i].exp_perr;
    end
    set_idle();
  endtask

  initial begin
    hold0 = '0; hold1 = '0; prev_d = '0; prev_v = 1'b0; prev_p = 1'b0;
    rst_n = 1'b0;
    set_idle();
    repeat (3) @(negedge clk);
    check_reset_values("por");

    // A write offered during INIT must be ignored; 0x00 has to read back cleared.
    rst_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 8'h00; req_wdata = 32'hFFFFFFFF;
    wait_init("init1");

    add_vec(1, 0, 4'h0, 8'h00, 32'h0,        1, 32'h00000000, 0);
    add_vec(1, 0, 4'h0, 8'hFF, 32'h0,        1, 32'h00000000, 0);
    add_vec(1, 1, 4'hF, 8'h10, 32'hAABBCCDD, 0, 32'h0, 0);
    add_vec(1, 1, 4'h5, 8'h10, 32'h11223344, 0, 32'h0, 0);
    add_vec(1, 0, 4'h0, 8'h10, 32'h0,        1, 32'hAA22CC44, 0);
    add_vec(1, 1, 4'hF, 8'h01, 32'h1,        0, 32'h0, 0);
    add_vec(1, 1, 4'hF, 8'h02, 32'h2,        0, 32'h0, 0);
    add_vec(1, 1, 4'hF, 8'h03, 32'h3,        0, 32'h0, 0);
    add_vec(1, 0, 4'h0, 8'h01, 32'h0,        1, 32'h1, 0);
    add_vec(1, 0, 4'h0, 8'h02, 32'h0,        1, 32'h2, 0);
    add_vec(1, 0, 4'h0, 8'h03, 32'h0,        1, 32'h3, 0);
    add_vec(0, 0, 4'h0, 8'h00, 32'h0,        0, 32'h0, 0);
    add_vec(0, 0, 4'h0, 8'h00, 32'h0,        0, 32'h0, 0);
    add_vec(1, 1, 4'hF, 8'h20, 32'h5,        0, 32'h0, 0);
    add_vec(1, 0, 4'h0, 8'h20, 32'h0,        1, 32'h5, 0);
    add_vec(1, 1, 4'h0, 8'h20, 32'hFFFFFFFF, 0, 32'h0, 0);
    add_vec(1, 0, 4'h0, 8'h20, 32'h0,        1, 32'h5, 0);
    add_vec(1, 1, 4'hF, 8'hFF, 32'hDEADBEEF, 0, 32'h0, 0);
    add_vec(1, 0, 4'h0, 8'hFF, 32'h0,        1, 32'hDEADBEEF, 0);
    add_vec(1, 1, 4'h8, 8'hFF, 32'h12000000, 0, 32'h0, 0);
    add_vec(1, 0, 4'h0, 8'hFF, 32'h0,        1, 32'h12ADBEEF, 0);
    add_vec(1, 1, 4'h2, 8'h10, 32'h0000EE00, 0, 32'h0, 0);
    add_vec(1, 0, 4'h0, 8'h10, 32'h0,        1, 32'hAA22EE44, 0);
    add_vec(0, 0, 4'h0, 8'h00, 32'h0,        0, 32'h0, 0);
    run_vectors("main");

    // Reset lands while the 2-cycle instance still has a read in flight.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    check_output("mid_valid0", rvalid0, 1);
    check_output("mid_rdata0", rdata0, 32'hAA22EE44);
    check_output("mid_valid1_pending", rvalid1, 0);
    set_idle();
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    check_reset_values("mid_rst_held");
    hold0 = '0; hold1 = '0; prev_v = 1'b0; prev_p = 1'b0;
    rst_n = 1'b1;
    wait_init("init2");

    vecs.delete();
    add_vec(1, 0, 4'h0, 8'h10, 32'h0,        1, 32'h00000000, 0);
    add_vec(1, 1, 4'hF, 8'h30, 32'h01020304, 0, 32'h0, 0);
    add_vec(1, 1, 4'hF, 8'h31, 32'h01020304, 0, 32'h0, 0);
    add_vec(0, 0, 4'h0, 8'h00, 32'h0,        0, 32'h0, 0);
    run_vectors("post");

`ifdef SPM_PARITY_EN
    dut0.mem[8'h30][0] = ~dut0.mem[8'h30][0];
    dut1.mem[8'h30][0] = ~dut1.mem[8'h30][0];
    vecs.delete();
    add_vec(1, 0, 4'h0, 8'h30, 32'h0, 1, 32'h01020305, 1);
    add_vec(1, 0, 4'h0, 8'h31, 32'h0, 1, 32'h01020304, 0);
    add_vec(0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0, 0);
    run_vectors("par");
`else
    vecs.delete();
    add_vec(1, 0, 4'h0, 8'h30, 32'h0, 1, 32'h01020304, 0);
    add_vec(1, 0, 4'h0, 8'h31, 32'h0, 1, 32'h01020304, 0);
    add_vec(0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h0, 0);
    run_vectors("nopar");
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
